// File: rtl/sm_uart_rom_loader.sv
// UART (8N1) receiver that packs four bytes little-endian into 32-bit words
// and strobes them into an instruction ROM at auto-incrementing addresses.
module sm_uart_rom_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  input  logic                  enable_i,
  output logic                  rom_we_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic [31:0]           rom_wdata_o,
  output logic                  byte_valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Valid/ready contract: none -- byte_valid_o, frame_err_o and rom_we_o are
  // single-cycle pulses with no back-pressure; the ROM must accept every strobe.

  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q;
  logic          frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              byte_valid_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A good byte is decided on the stop-bit sample edge; the assembler updates
  // on that same edge so rom_we_o lines up with byte_valid_o.
  logic byte_ok;
  assign byte_ok = (state_q == STOP) && (cnt_q == CNT_LAST) && rx_s_q;

  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    if (we_q) begin
      addr_d = addr_q + 1'b1;
    end
    if (!enable_i) begin
      byte_cnt_d = '0;
      addr_d     = '0;
    end else if (byte_ok) begin
      wdata_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
      byte_cnt_d = byte_cnt_q + 2'd1;
      we_d       = (byte_cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  assign rom_we_o     = we_q;
  assign rom_addr_o   = addr_q;
  assign rom_wdata_o  = wdata_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q != IDLE);

endmodule
